// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM state encoding and row-sample classification.
package keypad_pkg;

    localparam int MAX_ROWS = 64;
    localparam int IDX_W    = $clog2(MAX_ROWS);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    typedef enum logic [1:0] {
        CLS_IDLE,
        CLS_SINGLE,
        CLS_MULTI
    } sample_cls_t;

    typedef struct packed {
        sample_cls_t      cls;
        logic [IDX_W-1:0] idx;
    } sample_t;

    // Unused upper bits must be padded with ones so they read as released rows.
    function automatic sample_t classify(input logic [MAX_ROWS-1:0] r);
        sample_t s;
        int      zeros;
        zeros = 0;
        s.idx = '0;
        for (int i = 0; i < MAX_ROWS; i++) begin
            if (!r[i]) begin
                zeros++;
                s.idx = IDX_W'(i);
            end
        end
        if (zeros == 0)
            s.cls = CLS_IDLE;
        else if (zeros == 1)
            s.cls = CLS_SINGLE;
        else
            s.cls = CLS_MULTI;
        return s;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Column dwell counter; tick marks the last cycle of each dwell period.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/keypad_scanner.sv
// Self-scanning, debounced ROWS x COLS matrix keypad front end with press strobe,
// held level and multi-key rejection.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_key
);

    localparam int CIDX_W = $clog2(COLS);
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);

    logic                tick;
    state_t              state;
    logic [CIDX_W-1:0]   col_idx;
    logic [CIDX_W-1:0]   col_nxt;
    logic [ROWS-1:0]     pattern;
    logic [DEB_W-1:0]    deb_cnt;
    logic [DEB_W-1:0]    rel_cnt;
    logic [MAX_ROWS-1:0] row_pad;
    sample_t             smp;

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign row_pad = {{(MAX_ROWS - ROWS){1'b1}}, row};
    assign smp     = classify(row_pad);
    assign col_nxt = (col_idx == CIDX_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
    assign col     = ~(COLS'(1) << col_idx);

    // pattern/deb_cnt/rel_cnt are always loaded on entry to the state that reads them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_SCAN;
            col_idx   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_key <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (smp.cls == CLS_SINGLE) begin
                            pattern <= row;
                            deb_cnt <= DEB_W'(1);
                            state   <= ST_DEBOUNCE;
                        end else begin
                            multi_key <= (smp.cls == CLS_MULTI);
                            col_idx   <= col_nxt;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (smp.cls == CLS_SINGLE && row == pattern) begin
                            if (deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                key_code  <= CODE_W'(int'(col_idx) * ROWS + int'(smp.idx));
                                rel_cnt   <= '0;
                                state     <= ST_HELD;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            multi_key <= (smp.cls == CLS_MULTI);
                            col_idx   <= col_nxt;
                            state     <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        // Extra keys while held only restart the release count.
                        if (smp.cls == CLS_IDLE) begin
                            if (rel_cnt == DEB_W'(DEBOUNCE - 1)) begin
                                key_held <= 1'b0;
                                col_idx  <= col_nxt;
                                state    <= ST_SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed plus randomized bench for keypad_scanner with a tick-level reference model.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int CODE_W   = $clog2(ROWS * COLS);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ROWS-1:0]   row = '1;
    logic [COLS-1:0]   col;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;
    logic              multi_key;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_multi  = 0;

    // Reference model: mode 0=scanning, 1=confirming press, 2=key held
    int          m_phase = 0;
    int          m_col   = 0;
    int          m_mode  = 0;
    logic [3:0]  m_pat   = '1;
    int          m_seen  = 0;
    int          m_quiet = 0;
    int          e_code  = 0;
    logic        e_valid = 1'b0;
    logic        e_held  = 1'b0;
    logic        e_multi = 1'b0;

    keypad_scanner #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic advance_col();
        m_col = (m_col + 1) % COLS;
    endtask

    task automatic model_step();
        int   zeros;
        int   zidx;
        logic is_tick;
        if (!reset) begin
            m_phase = 0; m_col = 0; m_mode = 0;
            e_code = 0; e_valid = 0; e_held = 0; e_multi = 0;
            return;
        end
        e_valid = 0;
        e_multi = 0;
        is_tick = (m_phase == SCAN_DIV - 1);
        m_phase = is_tick ? 0 : m_phase + 1;
        if (!is_tick) return;
        zeros = 0;
        zidx  = 0;
        for (int i = 0; i < ROWS; i++)
            if (row[i] == 1'b0) begin zeros++; zidx = i; end
        case (m_mode)
            0: begin
                if (zeros == 1) begin m_pat = row; m_seen = 1; m_mode = 1; end
                else begin e_multi = (zeros > 1); advance_col(); end
            end
            1: begin
                if (zeros == 1 && row == m_pat) begin
                    m_seen++;
                    if (m_seen == DEBOUNCE) begin
                        e_valid = 1; e_held = 1; e_code = m_col * ROWS + zidx;
                        m_mode = 2; m_quiet = 0;
                    end
                end else begin
                    e_multi = (zeros > 1); m_mode = 0; advance_col();
                end
            end
            default: begin
                if (zeros == 0) begin
                    m_quiet++;
                    if (m_quiet == DEBOUNCE) begin e_held = 0; m_mode = 0; advance_col(); end
                end else m_quiet = 0;
            end
        endcase
    endtask

    task automatic cycle();
        logic [COLS-1:0] e_col;
        @(posedge clk);
        model_step();
        #1;
        e_col = ~(4'b0001 << m_col);
        chk("col", 32'(col), 32'(e_col));
        chk("key_valid", 32'(key_valid), 32'(e_valid));
        chk("key_held", 32'(key_held), 32'(e_held));
        chk("multi_key", 32'(multi_key), 32'(e_multi));
        chk("key_code", 32'(key_code), 32'(e_code));
        chk("valid_multi_excl", 32'(key_valid & multi_key), 32'd0);
        if (key_valid === 1'b1) n_valid++;
        if (multi_key === 1'b1) n_multi++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_scan_col(input int c);
        int budget;
        budget = 200;
        while (!(m_mode == 0 && m_col == c && m_phase == 0) && budget > 0) begin
            cycle();
            budget--;
        end
        chk("wait_col_timeout", 32'(budget == 0), 32'd0);
    endtask

    int v0;
    int mk0;
    int hold_len;
    int r;

    initial begin
        // Reset and idle scanning
        reset = 1'b0;
        row   = '1;
        run(3);
        chk("rst_col", 32'(col), 32'h0000000e);
        chk("rst_code", 32'(key_code), 32'd0);
        reset = 1'b1;
        run(64);
        chk("idle_no_valid", 32'(n_valid), 32'd0);
        chk("idle_no_multi", 32'(n_multi), 32'd0);

        // Clean press at col 2 row 1
        wait_scan_col(2);
        v0  = n_valid;
        row = 4'b1101;
        run(24);
        chk("press_code9", 32'(key_code), 32'd9);
        chk("press_held", 32'(key_held), 32'd1);
        chk("press_one_pulse", 32'(n_valid - v0), 32'd1);
        row = '1;
        run(16);
        chk("release_held", 32'(key_held), 32'd0);

        // Bounce: pressed for one tick only
        wait_scan_col(1);
        v0  = n_valid;
        row = 4'b1101;
        run(SCAN_DIV);
        row = '1;
        run(16);
        chk("bounce_no_valid", 32'(n_valid - v0), 32'd0);

        // Two rows low in one sample
        wait_scan_col(0);
        v0  = n_valid;
        mk0 = n_multi;
        row = 4'b1001;
        run(SCAN_DIV);
        row = '1;
        run(8);
        chk("multi_pulse", 32'(n_multi - mk0), 32'd1);
        chk("multi_no_valid", 32'(n_valid - v0), 32'd0);

        // Col 3 row 3, second key while held, then a fresh press
        wait_scan_col(3);
        v0  = n_valid;
        mk0 = n_multi;
        row = 4'b0111;
        run(20);
        chk("c3r3_code15", 32'(key_code), 32'd15);
        row = 4'b0110;
        run(20);
        chk("held_second_ignored", 32'(n_valid - v0), 32'd1);
        chk("held_no_multi", 32'(n_multi - mk0), 32'd0);
        row = '1;
        run(16);
        wait_scan_col(1);
        row = 4'b1011;
        run(20);
        chk("fresh_press_pulse", 32'(n_valid - v0), 32'd2);
        chk("fresh_code6", 32'(key_code), 32'd6);
        row = '1;
        run(16);

        // Reset while debouncing
        wait_scan_col(2);
        v0  = n_valid;
        row = 4'b1110;
        run(SCAN_DIV + 2);
        chk("in_debounce", 32'(m_mode), 32'd1);
        reset = 1'b0;
        cycle();
        chk("rstdeb_code", 32'(key_code), 32'd0);
        chk("rstdeb_col", 32'(col), 32'h0000000e);
        chk("rstdeb_held", 32'(key_held), 32'd0);
        reset = 1'b1;
        row   = '1;
        run(20);
        chk("rstdeb_no_valid", 32'(n_valid - v0), 32'd0);

        // Randomized key activity
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 50)
                row = '1;
            else if (r < 85)
                row = ~(4'b0001 << $urandom_range(0, ROWS - 1));
            else
                row = 4'($urandom);
            hold_len = $urandom_range(1, 16);
            run(hold_len);
        end
        row = '1;
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
